alu_mdu: RTL and testbench

ALU_MDU -- requirements
Module: alu_mdu

---
 rtl/alu_mdu.sv | 194 +++++++++++++++++++
 tb/tb_alu_mdu.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_mdu.sv
// Integer ALU plus iterative multiply/divide unit with valid/ready handshakes.
// Base ops complete one cycle after accept; M ops take XLEN+1 cycles.
module alu_mdu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [4:0]      opcode_in,
  input  logic [XLEN-1:0] op_1_in,
  input  logic [XLEN-1:0] op_2_in,
  output logic            valid_out,
  input  logic            ready_in,
  output logic [XLEN-1:0] result_out
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2*XLEN-1:0] work_q, work_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [2:0]        func_q, func_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic              bzero_q, bzero_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;

  // Single-cycle base operations
  logic [XLEN-1:0] alu_res;
  logic [SHW-1:0]  shamt;

  always_comb begin
    shamt = op_2_in[SHW-1:0];
    case (opcode_in[3:0])
      4'b0000: alu_res = op_1_in + op_2_in;
      4'b1000: alu_res = op_1_in - op_2_in;
      4'b0010: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_1_in) < $signed(op_2_in))};
      4'b0011: alu_res = {{(XLEN-1){1'b0}}, (op_1_in < op_2_in)};
      4'b0111: alu_res = op_1_in & op_2_in;
      4'b0110: alu_res = op_1_in | op_2_in;
      4'b0100: alu_res = op_1_in ^ op_2_in;
      4'b0001: alu_res = op_1_in << shamt;
      4'b0101: alu_res = op_1_in >> shamt;
      4'b1101: alu_res = $signed(op_1_in) >>> shamt;
      default: alu_res = '0;
    endcase
  end

  // Operand magnitudes; the iterative core works on unsigned values only
  logic [2:0]      f_in;
  logic            a_signed, b_signed, neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;

  always_comb begin
    f_in     = opcode_in[2:0];
    a_signed = (f_in == 3'b001) || (f_in == 3'b010) || (f_in == 3'b100) || (f_in == 3'b110);
    b_signed = (f_in == 3'b001) || (f_in == 3'b100) || (f_in == 3'b110);
    neg_a    = a_signed & op_1_in[XLEN-1];
    neg_b    = b_signed & op_2_in[XLEN-1];
    mag_a    = neg_a ? -op_1_in : op_1_in;
    mag_b    = neg_b ? -op_2_in : op_2_in;
  end

  // One iteration: work holds {acc/remainder, multiplier/quotient}
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] work_step;

  always_comb begin
    mul_sum   = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    div_shift = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_ge    = ~div_diff[XLEN];
    if (func_q[2]) begin
      work_step = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                   work_q[XLEN-2:0], div_ge};
    end else begin
      work_step = {mul_sum, work_q[XLEN-1:1]};
    end
  end

  // Sign fix-up and divide-by-zero override on the final iteration's value
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo, rem, m_res;

  always_comb begin
    prod_s = (sa_q ^ sb_q) ? -work_step : work_step;
    quo    = work_step[XLEN-1:0];
    rem    = work_step[2*XLEN-1:XLEN];
    case (func_q)
      3'b000:         m_res = prod_s[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         m_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101: m_res = bzero_q ? {XLEN{1'b1}} : ((sa_q ^ sb_q) ? -quo : quo);
      default:        m_res = bzero_q ? a_q : (sa_q ? -rem : rem);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    work_d   = work_q;
    opb_d    = opb_q;
    a_d      = a_q;
    func_d   = func_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    bzero_d  = bzero_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          a_d    = op_1_in;
          func_d = opcode_in[2:0];
          if (opcode_in[4]) begin
            state_d = CALC;
            cnt_d   = '0;
            sa_d    = neg_a;
            sb_d    = neg_b;
            bzero_d = (op_2_in == '0);
            if (opcode_in[2]) begin
              work_d = {{XLEN{1'b0}}, mag_a};
              opb_d  = mag_b;
            end else begin
              work_d = {{XLEN{1'b0}}, mag_b};
              opb_d  = mag_a;
            end
          end else begin
            state_d  = DONE;
            result_d = alu_res;
          end
        end
      end
      CALC: begin
        work_d = work_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d  = DONE;
          cnt_d    = '0;
          result_d = m_res;
        end
      end
      DONE: begin
        if (ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      work_q   <= '0;
      opb_q    <= '0;
      a_q      <= '0;
      func_q   <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bzero_q  <= 1'b0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      work_q   <= work_d;
      opb_q    <= opb_d;
      a_q      <= a_d;
      func_q   <= func_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      bzero_q  <= bzero_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
    end
  end

  assign ready_out  = ready_q;
  assign valid_out  = valid_q;
  assign result_out = result_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu at XLEN=32.
module tb_alu_mdu;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic        ready_out;
  logic [4:0]  opcode_in;
  logic [31:0] op_1_in;
  logic [31:0] op_2_in;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] result_out;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b01000, SLT = 5'b00010, SLTU = 5'b00011,
                         XOR_OP = 5'b00100, SLL = 5'b00001, SRA = 5'b01101;
  localparam logic [4:0] MUL = 5'b10000, MULH = 5'b10001, MULHSU = 5'b10010, MULHU = 5'b10011,
                         DIV = 5'b10100, DIVU = 5'b10101, REM = 5'b10110, REMU = 5'b10111;

  alu_mdu #(.XLEN(32)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .opcode_in  (opcode_in),
    .op_1_in    (op_1_in),
    .op_2_in    (op_2_in),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .result_out (result_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Accept one op with ready_in=1, measure cycles to valid_out, check result and return to IDLE
  task automatic run_op(input string tag, input logic [4:0] opc, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int cyc;
    chk({tag, " ready_pre"}, 64'(ready_out), 64'd1);
    valid_in  = 1'b1;
    opcode_in = opc;
    op_1_in   = a;
    op_2_in   = b;
    tick();
    valid_in  = 1'b0;
    op_1_in   = $urandom;
    op_2_in   = $urandom;
    opcode_in = 5'($urandom);
    cyc = 1;
    while (!valid_out && cyc < 200) begin
      tick();
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    chk({tag, " result"}, 64'(result_out), 64'(exp_res));
    tick();
    chk({tag, " ready_post"}, 64'(ready_out), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    rst_in    = 1'b1;
    valid_in  = 1'b0;
    ready_in  = 1'b1;
    opcode_in = '0;
    op_1_in   = '0;
    op_2_in   = '0;
    tick();
    tick();
    rst_in = 1'b0;
    chk("reset valid_out", 64'(valid_out), 64'd0);
    chk("reset result_out", 64'(result_out), 64'd0);
    chk("reset ready_out", 64'(ready_out), 64'd1);

    run_op("ADD wrap", ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1);
    run_op("SUB", SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1);
    run_op("XOR", XOR_OP, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1);
    run_op("illegal base", 5'b01001, 32'h12345678, 32'h1, 32'h00000000, 1);
    run_op("SRA", SRA, 32'h80000000, 32'h00000024, 32'hF8000000, 1);
    run_op("SLL", SLL, 32'h00000001, 32'h00000021, 32'h00000002, 1);
    run_op("SLT", SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1);
    run_op("SLTU", SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);

    run_op("MULH", MULH, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 33);
    run_op("MULHU", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("MUL", MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
    run_op("MULHSU", MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_op("MUL bit3", 5'b11000, 32'd3, 32'd4, 32'd12, 33);

    run_op("DIV by0", DIV, 32'd7, 32'd0, 32'hFFFFFFFF, 33);
    run_op("REM by0", REM, 32'd7, 32'd0, 32'h00000007, 33);
    run_op("DIV ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    run_op("REM ovf", REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
    run_op("DIV neg", DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_op("REM neg", REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_op("DIVU", DIVU, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 33);
    run_op("REMU", REMU, 32'd100, 32'd7, 32'd2, 33);

    // Consumer stalls while the producer keeps offering new work
    ready_in  = 1'b0;
    valid_in  = 1'b1;
    opcode_in = ADD;
    op_1_in   = 32'h10;
    op_2_in   = 32'h20;
    tick();
    chk("stall valid_first", 64'(valid_out), 64'd1);
    for (int i = 0; i < 5; i++) begin
      op_1_in   = $urandom;
      op_2_in   = $urandom;
      opcode_in = {1'b0, 4'($urandom)};
      tick();
      chk("stall valid_out", 64'(valid_out), 64'd1);
      chk("stall result_out", 64'(result_out), 64'h30);
      chk("stall ready_out", 64'(ready_out), 64'd0);
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    tick();
    chk("release ready_out", 64'(ready_out), 64'd1);
    chk("release valid_out", 64'(valid_out), 64'd0);
    chk("release result kept", 64'(result_out), 64'h30);
    tick();
    chk("idle result kept", 64'(result_out), 64'h30);

    // Reset in the middle of a divide, with a competing request
    valid_in  = 1'b1;
    opcode_in = DIVU;
    op_1_in   = 32'd100;
    op_2_in   = 32'd3;
    tick();
    valid_in = 1'b0;
    repeat (9) tick();
    chk("calc ready_out", 64'(ready_out), 64'd0);
    rst_in    = 1'b1;
    valid_in  = 1'b1;
    opcode_in = ADD;
    op_1_in   = 32'd9;
    op_2_in   = 32'd9;
    tick();
    rst_in   = 1'b0;
    valid_in = 1'b0;
    chk("midreset valid_out", 64'(valid_out), 64'd0);
    chk("midreset result_out", 64'(result_out), 64'd0);
    chk("midreset ready_out", 64'(ready_out), 64'd1);
    tick();
    chk("midreset no_accept", 64'(valid_out), 64'd0);
    run_op("ADD after reset", ADD, 32'd2, 32'd3, 32'd5, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
